// File: rtl/piso_ctrl_pkg.sv
// Shared types and helpers for the PISO transmit sequencing controller.
`timescale 1ns/1ps
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 0;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_W     = 32;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry valid/ready holding register; a push in the same cycle as a pop refills it.
`timescale 1ns/1ps
module piso_hold_reg
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic push;

    // pop comes only from controller state, so in_ready never depends on in_valid.
    assign in_ready = !full || pop;
    assign push     = in_valid && in_ready;

    // NOTE: the data register is reset as well, so piso_A is a defined zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            data <= in_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_tx_ctrl.sv
// Sequences an external 4-bit PISO: loads held words, frames the serial stream, counts frames.
`timescale 1ns/1ps
module piso_tx_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int GAP       = DEF_GAP,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] piso_A,
    output logic             piso_S,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             state, state_n;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [CNT_W-1:0]   frame_cnt_n;
    logic               load;
    logic               last_bit;
    logic               hold_full;
    logic [WIDTH-1:0]   hold_data;
    logic [WIDTH-1:0]   hold_rev;

    piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pop      (load),
        .full     (hold_full),
        .data     (hold_data)
    );

    assign hold_rev = WIDTH'(bit_reverse(MAX_W'(hold_data), WIDTH));
    assign last_bit = (state == SHIFT) && (bit_cnt == BIT_W'(WIDTH - 1));
    assign busy     = (state != IDLE) || hold_full;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    // The GAP parameter shadows the package state of the same name, hence the qualified reference.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_full) load = 1'b1;
            end
            SHIFT: begin
                if (!last_bit) begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                end else if (GAP == 0 && hold_full) begin
                    load = 1'b1;
                end else if (GAP > 0) begin
                    state_n   = piso_ctrl_pkg::GAP;
                    gap_cnt_n = GAP_W'(GAP - 1);
                end else begin
                    state_n = IDLE;
                end
            end
            piso_ctrl_pkg::GAP: begin
                if (gap_cnt != '0)  gap_cnt_n = gap_cnt - GAP_W'(1);
                else if (hold_full) load      = 1'b1;
                else                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n   = SHIFT;
            bit_cnt_n = '0;
        end
        frame_cnt_n = frame_cnt + CNT_W'(load);
    end

    always_comb begin
        piso_S      = !load;
        piso_A      = (load && !MSB_FIRST) ? hold_rev : hold_data;
        ser_valid   = (state == SHIFT);
        frame_start = ser_valid && (bit_cnt == '0);
        frame_end   = last_bit;
    end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench: three controller variants (GAP=0, GAP=2, LSB-first), each driving a behavioural PISO.
`timescale 1ns/1ps
module tb_piso_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0][3:0] in_data;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready;
    logic [2:0][3:0] piso_A;
    logic [2:0]      piso_S;
    logic [2:0]      ser_valid;
    logic [2:0]      frame_start;
    logic [2:0]      frame_end;
    logic [2:0]      busy;
    logic [2:0][7:0] frame_cnt;
    logic [2:0]      data_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [3:0] q;

        piso_tx_ctrl #(
            .WIDTH     (4),
            .GAP       ((g == 1) ? 2 : 0),
            .MSB_FIRST ((g == 2) ? 1'b0 : 1'b1),
            .CNT_W     (8)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_data     (in_data[g]),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .piso_A      (piso_A[g]),
            .piso_S      (piso_S[g]),
            .ser_valid   (ser_valid[g]),
            .frame_start (frame_start[g]),
            .frame_end   (frame_end[g]),
            .busy        (busy[g]),
            .frame_cnt   (frame_cnt[g])
        );

        // PISO: S=0 loads A, S=1 shifts toward the MSB; data_out is the MSB.
        always @(posedge clk) q <= piso_S[g] ? {q[2:0], 1'b0} : piso_A[g];
        assign data_out[g] = q[3];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one WIDTH-bit frame; bits[3] is the first serial bit expected.
    task automatic expect_frame(input int c, input logic [3:0] bits, input logic reload);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ch%0d bit%0d {valid,start,end,dout,S}", c, i),
                  32'({ser_valid[c], frame_start[c], frame_end[c], data_out[c], piso_S[c]}),
                  32'({1'b1, i == 0, i == 3, bits[3-i], !(reload && i == 3)}));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] words;
        logic [11:0] rx;
        int widx, nbits, nstall, nacc, nsv, first_sv, last_sv;

        in_data  = '0;
        in_valid = '0;

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("reset {ready,S,A,valid,start,end,busy}",
              32'({in_ready[0], piso_S[0], piso_A[0], ser_valid[0], frame_start[0], frame_end[0], busy[0]}),
              32'({1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("reset frame_cnt", 32'(frame_cnt[0]), 32'd0);
        rst = 1'b0;
        tick();

        // Single word, GAP=0
        in_data[0]  = 4'b0111;
        in_valid[0] = 1'b1;
        check("t1 ready idle", 32'(in_ready[0]), 32'd1);
        tick();
        in_valid[0] = 1'b0;
        check("t1 load {S,A,valid,busy}",
              32'({piso_S[0], piso_A[0], ser_valid[0], busy[0]}), 32'({1'b0, 4'b0111, 1'b0, 1'b1}));
        tick();
        check("t1 frame_cnt", 32'(frame_cnt[0]), 32'd1);
        expect_frame(0, 4'b0111, 1'b0);
        check("t1 after {valid,busy}", 32'({ser_valid[0], busy[0]}), 32'd0);

        // Back-to-back, GAP=0: second accept coincides with the first pop
        in_data[0]  = 4'b0111;
        in_valid[0] = 1'b1;
        tick();
        check("t2 pop cycle {ready,S}", 32'({in_ready[0], piso_S[0]}), 32'b10);
        in_data[0] = 4'b0101;
        tick();
        in_valid[0] = 1'b0;
        expect_frame(0, 4'b0111, 1'b1);
        expect_frame(0, 4'b0101, 1'b0);
        check("t2 after {valid,busy}", 32'({ser_valid[0], busy[0]}), 32'd0);
        check("t2 frame_cnt", 32'(frame_cnt[0]), 32'd3);

        // Back-to-back with GAP=2
        in_data[1]  = 4'b0111;
        in_valid[1] = 1'b1;
        tick();
        in_data[1] = 4'b0101;
        tick();
        in_valid[1] = 1'b0;
        expect_frame(1, 4'b0111, 1'b0);
        check("t3 gap1 {valid,S}", 32'({ser_valid[1], piso_S[1]}), 32'b01);
        tick();
        check("t3 gap2 {valid,S}", 32'({ser_valid[1], piso_S[1]}), 32'b00);
        tick();
        expect_frame(1, 4'b0101, 1'b0);
        check("t3 frame_cnt", 32'(frame_cnt[1]), 32'd2);

        // LSB-first variant
        in_data[2]  = 4'b0001;
        in_valid[2] = 1'b1;
        tick();
        in_valid[2] = 1'b0;
        check("t4 load {S,A}", 32'({piso_S[2], piso_A[2]}), 32'({1'b0, 4'b1000}));
        tick();
        expect_frame(2, 4'b1000, 1'b0);

        // Backpressure across three words
        words = 12'hA5F;
        rx = '0;
        widx = 0; nbits = 0; nstall = 0; nacc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid[0] = (widx < 3);
            if (widx < 3) in_data[0] = words[11 - 4*widx -: 4];
            if (ser_valid[0]) begin
                rx = {rx[10:0], data_out[0]};
                nbits++;
            end
            if (in_valid[0]) begin
                if (in_ready[0]) begin
                    nacc++;
                    widx++;
                end else begin
                    nstall++;
                end
            end
            tick();
        end
        in_valid[0] = 1'b0;
        check("t5 accepts", 32'(nacc), 32'd3);
        check("t5 stall cycles", 32'(nstall), 32'd3);
        check("t5 bit count", 32'(nbits), 32'd12);
        check("t5 stream", 32'(rx), 32'h0A5F);
        check("t5 frame_cnt", 32'(frame_cnt[0]), 32'd6);

        // Reset on the 2nd bit of a frame with the holding register full
        in_data[0]  = 4'b0011;
        in_valid[0] = 1'b1;
        tick();
        in_data[0] = 4'b1100;
        tick();
        in_valid[0] = 1'b0;
        tick();
        check("t6 2nd bit {valid,dout,busy}", 32'({ser_valid[0], data_out[0], busy[0]}), 32'b101);
        rst = 1'b1;
        #1;
        check("t6 async {ready,S,A,valid,start,end,busy}",
              32'({in_ready[0], piso_S[0], piso_A[0], ser_valid[0], frame_start[0], frame_end[0], busy[0]}),
              32'({1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("t6 async frame_cnt", 32'(frame_cnt[0]), 32'd0);
        #2;
        rst = 1'b0;
        nsv = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (ser_valid[0]) nsv++;
        end
        check("t6 no held word emitted", 32'(nsv), 32'd0);
        check("t6 post {ready,busy}", 32'({in_ready[0], busy[0]}), 32'b10);
        check("t6 post frame_cnt", 32'(frame_cnt[0]), 32'd0);

        // Continuous stream of 256 words: full throughput and frame_cnt wrap
        in_data[0]  = 4'b1001;
        in_valid[0] = 1'b1;
        nacc = 0; nsv = 0; first_sv = -1; last_sv = -1;
        for (int cyc = 0; cyc < 1100 && nacc < 256; cyc++) begin
            if (ser_valid[0]) begin
                nsv++;
                if (first_sv < 0) first_sv = cyc;
                last_sv = cyc;
            end
            if (in_ready[0]) nacc++;
            tick();
        end
        in_valid[0] = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (ser_valid[0]) nsv++;
            tick();
        end
        check("t7 accepts", 32'(nacc), 32'd256);
        check("t7 valid bits", 32'(nsv), 32'd1024);
        check("t7 contiguous before drain", 32'(last_sv - first_sv + 1), 32'(nsv - 8));
        check("t7 frame_cnt wrapped", 32'(frame_cnt[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
